// File: rtl/exp_align_alu.sv
// exp_align_alu: two-stage pipelined exponent-alignment ALU for the FP adder.
// Stage 1 captures the operands and the mode. Stage 2 computes and registers
// the mode result, borrow, swap, max exponent and mantissa shift amount.
// Build option: define EXP_ALIGN_SAT_EN to clamp shamt at MAX_SHIFT. Without
// it, shamt is the low SHW bits of |A-B| and no clamp comparator is built.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds valid and its data stable until that transfer.
// in_ready is the only output that depends combinationally on an input
// (out_ready).
module exp_align_alu #(
  parameter int          EW        = 8,
  parameter int          SHW       = 5,
  parameter int unsigned MAX_SHIFT = 27
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [EW-1:0]  a_exp,
  input  logic [EW-1:0]  b_exp,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [EW-1:0]  result,
  output logic           borrow,
  output logic           swap,
  output logic [EW-1:0]  big_exp,
  output logic [SHW-1:0] shamt
);

  logic           s1_valid;
  logic [EW-1:0]  s1_a;
  logic [EW-1:0]  s1_b;
  logic [1:0]     s1_mode;

  logic           s2_load;
  logic           accept;

  logic [EW:0]    a_minus_b;
  logic [EW:0]    b_minus_a;
  logic           a_ge_b;
  logic [EW-1:0]  abs_diff;
  logic [EW-1:0]  nxt_result;
  logic [EW-1:0]  nxt_big;
  logic           nxt_borrow;
  logic           nxt_swap;
  logic [SHW-1:0] nxt_shamt;

  // The output register can take new data when it is empty or being consumed.
  // Stage 1 can accept when it is empty or is moving into stage 2 this cycle.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  // Mode-independent compare plus the mode-selected result and flags.
  always_comb begin
    a_minus_b  = {1'b0, s1_a} - {1'b0, s1_b};
    b_minus_a  = {1'b0, s1_b} - {1'b0, s1_a};
    a_ge_b     = !a_minus_b[EW];
    abs_diff   = a_ge_b ? a_minus_b[EW-1:0] : b_minus_a[EW-1:0];
    nxt_big    = a_ge_b ? s1_a : s1_b;
    nxt_result = '0;
    nxt_borrow = 1'b0;
    nxt_swap   = 1'b0;
    case (s1_mode)
      2'b00: begin
        nxt_result = b_minus_a[EW-1:0];
        nxt_borrow = b_minus_a[EW];
      end
      2'b01: begin
        nxt_result = a_minus_b[EW-1:0];
        nxt_borrow = a_minus_b[EW];
      end
      2'b10: begin
        nxt_result = s1_a;
      end
      default: begin
        nxt_result = abs_diff;
        nxt_swap   = !a_ge_b;
      end
    endcase
  end

`ifdef EXP_ALIGN_SAT_EN
  // Clamp the shift so the alignment shifter never sees more than MAX_SHIFT.
  always_comb begin
    if (32'(abs_diff) > MAX_SHIFT) nxt_shamt = SHW'(MAX_SHIFT);
    else                           nxt_shamt = SHW'(abs_diff);
  end
`else
  // Raw low bits; the downstream shifter flushes large shifts to sticky itself.
  assign nxt_shamt = SHW'(abs_diff);
`endif

  // Stage 1: capture operands on handshake, empty when handed to stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= a_exp;
      s1_b     <= b_exp;
      s1_mode  <= mode;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output registers; they hold unchanged while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      borrow    <= 1'b0;
      swap      <= 1'b0;
      big_exp   <= '0;
      shamt     <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= nxt_result;
        borrow  <= nxt_borrow;
        swap    <= nxt_swap;
        big_exp <= nxt_big;
        shamt   <= nxt_shamt;
      end
    end
  end

endmodule

// File: tb/tb_exp_align_alu.sv
// tb_exp_align_alu: directed and random checks of exp_align_alu (EW=8) plus a
// single-shot check of an EW=11 instance. Honours EXP_ALIGN_SAT_EN.
module tb_exp_align_alu;

  typedef struct packed {
    logic [7:0] result;
    logic       borrow;
    logic       swap;
    logic [7:0] big;
    logic [4:0] shamt;
  } res_t;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_exp;
  logic [7:0] b_exp;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       borrow;
  logic       swap;
  logic [7:0] big_exp;
  logic [4:0] shamt;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [10:0] w_a_exp;
  logic [10:0] w_b_exp;
  logic [1:0]  w_mode;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [10:0] w_result;
  logic        w_borrow;
  logic        w_swap;
  logic [10:0] w_big_exp;
  logic [5:0]  w_shamt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_align_alu #(.EW(8), .SHW(5), .MAX_SHIFT(27)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_exp(a_exp), .b_exp(b_exp), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .borrow(borrow), .swap(swap),
    .big_exp(big_exp), .shamt(shamt)
  );

  exp_align_alu #(.EW(11), .SHW(6), .MAX_SHIFT(56)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a_exp(w_a_exp), .b_exp(w_b_exp), .mode(w_mode), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .result(w_result), .borrow(w_borrow), .swap(w_swap),
    .big_exp(w_big_exp), .shamt(w_shamt)
  );

  // ---------------- counters and scoreboard ----------------
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic [22:0] exp_q[$];
  int   acc_log[$];
  int   pop_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules, using signed integers.
  function automatic res_t model(input int a, input int b, input int m);
    res_t r;
    int   ad;
    ad = (a >= b) ? a - b : b - a;
    r.big = 8'((a > b) ? a : b);
`ifdef EXP_ALIGN_SAT_EN
    r.shamt = 5'((ad > 27) ? 27 : ad);
`else
    r.shamt = 5'(ad % 32);
`endif
    r.swap = 1'b0;
    case (m)
      0: begin r.result = 8'((b - a + 256) % 256); r.borrow = (b < a); end
      1: begin r.result = 8'((a - b + 256) % 256); r.borrow = (a < b); end
      2: begin r.result = 8'(a); r.borrow = 1'b0; end
      default: begin r.result = 8'(ad); r.borrow = 1'b0; r.swap = (b > a); end
    endcase
    return r;
  endfunction

  // Monitor: pop and compare on each output transfer, push model on each
  // accepted input, and require frozen outputs across stalled cycles.
  res_t obs;
  res_t snap;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      obs = '{result, borrow, swap, big_exp, shamt};
      if (prev_stall) check("stall_hold", {out_valid, obs}, {1'b1, snap});
      if (out_valid && out_ready) begin
        pop_log.push_back(cyc);
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else check("sb_result", obs, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        acc_log.push_back(cyc + 1);
        exp_q.push_back(model(int'(a_exp), int'(b_exp), int'(mode)));
      end
      prev_stall = out_valid && !out_ready;
      snap = obs;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set (caller is just after a rising edge); return just
  // after the edge that accepted it.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    bit ok = 0;
    in_valid = 1'b1;
    a_exp = a;
    b_exp = b;
    mode = m;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  // Wait for out_valid at a falling edge; lat counts falling edges waited.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
    end
    if (lat < 0) check("wait_out_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    check("drain_done", ok, 1);
  endtask

  function automatic logic [7:0] rand_b(input logic [7:0] a);
    case ($urandom_range(0, 3))
      0: return a;
      1: return a + 8'($urandom_range(0, 40));
      2: return a - 8'($urandom_range(0, 40));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- directed and random sequence ----------------
  int   lat;
  int   n_acc;
  bit   acc;
  logic [7:0] ra;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a_exp = '0; b_exp = '0; mode = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_a_exp = '0; w_b_exp = '0; w_mode = '0; w_out_ready = 1'b1;
    #1;
    check("rst_outputs", {out_valid, result, borrow, swap, big_exp, shamt}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);

    // Per-mode results with A=0x85, B=0x80.
    step();
    send(8'h85, 8'h80, 2'b00);
    wait_out(lat);
    check("latency", lat, 2);
    check("m00_result", result, 8'hFB);
    check("m00_borrow", borrow, 1);
    check("m00_shamt", shamt, 5);
    check("m00_big", big_exp, 8'h85);
    check("m00_swap", swap, 0);
    step();
    send(8'h85, 8'h80, 2'b01);
    wait_out(lat);
    check("m01_result", result, 8'h05);
    check("m01_borrow", borrow, 0);
    step();
    send(8'h85, 8'h80, 2'b10);
    wait_out(lat);
    check("m10_result", result, 8'h85);
    check("m10_borrow", borrow, 0);

    // Auto mode with swap and saturation edge, then equal exponents.
    step();
    send(8'h10, 8'h7F, 2'b11);
    wait_out(lat);
    check("m11_result", result, 8'h6F);
    check("m11_swap", swap, 1);
    check("m11_big", big_exp, 8'h7F);
    check("m11_borrow", borrow, 0);
`ifdef EXP_ALIGN_SAT_EN
    check("m11_shamt", shamt, 27);
`else
    check("m11_shamt", shamt, 5'h0F);
`endif
    step();
    send(8'h40, 8'h40, 2'b11);
    wait_out(lat);
    check("eq_result", result, 0);
    check("eq_swap", swap, 0);
    check("eq_shamt", shamt, 0);
    drain();

    // Wide instance: EW=11, SHW=6, MAX_SHIFT=56.
    step();
    w_in_valid = 1'b1; w_a_exp = 11'h7FE; w_b_exp = 11'h001; w_mode = 2'b11;
    step();
    w_in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (w_out_valid) begin lat = i; break; end
    end
    check("w_out_valid", lat >= 0, 1);
    check("w_result", w_result, 11'h7FD);
    check("w_swap", w_swap, 0);
    check("w_big", w_big_exp, 11'h7FE);
`ifdef EXP_ALIGN_SAT_EN
    check("w_shamt", w_shamt, 56);
`else
    check("w_shamt", w_shamt, 6'h3D);
`endif

    // Back-to-back streaming: 8 accepts on consecutive edges, 8 results out.
    step();
    acc_log.delete();
    pop_log.delete();
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      send(ra, rand_b(ra), 2'($urandom_range(0, 3)));
    end
    drain();
    check("stream_acc_n", acc_log.size(), 8);
    check("stream_pop_n", pop_log.size(), 8);
    if (acc_log.size() == 8 && pop_log.size() == 8)
      for (int i = 0; i < 8; i++) begin
        check("stream_acc_cyc", acc_log[i], acc_log[0] + i);
        check("stream_pop_cyc", pop_log[i], acc_log[0] + 1 + i);
      end

    // Backpressure: 2 accepts fill the pipe, third waits while stalled.
    step();
    pop_log.delete();
    out_ready = 1'b0;
    send(8'h20, 8'h05, 2'b00);
    send(8'h33, 8'h90, 2'b11);
    in_valid = 1'b1; a_exp = 8'hC8; b_exp = 8'hC0; mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1; break; end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_third_accept", acc, 1);
    drain();
    check("bp_pop_n", pop_log.size(), 3);

    // Random stream with random backpressure.
    step();
    n_acc = 0;
    for (int i = 0; i < 2000 && n_acc < 40; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) n_acc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        if ($urandom_range(0, 3) == 0) in_valid = 1'b0;
        else begin
          in_valid = 1'b1;
          ra = 8'($urandom_range(0, 255));
          a_exp = ra;
          b_exp = rand_b(ra);
          mode = 2'($urandom_range(0, 3));
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rand_accepts", n_acc, 40);
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    send(8'h01, 8'h02, 2'b00);
    send(8'h03, 8'h04, 2'b01);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {out_valid, result, borrow, swap, big_exp, shamt}, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
    end
    step();
    send(8'h0A, 8'h03, 2'b01);
    wait_out(lat);
    check("post_rst_result", result, 8'h07);
    drain();
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
